// File: rtl/sd_dat_xfer_ctrl_pkg.sv
// Shared types and constants for the SD DAT-line transfer sequencer.
// The state, issue and flag encodings are visible to both the RTL and the bench.
package sd_dat_xfer_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WBUF,
        ST_OP,
        ST_COMP,
        ST_BUSY,
        ST_PAUSED,
        ST_RWAIT,
        ST_WGAP,
        ST_ACMD12,
        ST_ERROR
    } xfer_state_e;

    typedef enum logic [1:0] {
        ISSUE_NONE  = 2'b00,
        ISSUE_READ  = 2'b01,
        ISSUE_WRITE = 2'b10,
        ISSUE_BUSY  = 2'b11
    } issue_e;

    // Bit positions inside blk_err / data_err, and inside xfer_active.
    localparam int ERR_CRC     = 0;
    localparam int ERR_END_BIT = 1;
    localparam int ERR_TIMEOUT = 2;

    localparam int FLAG_READ  = 0;
    localparam int FLAG_WRITE = 1;
    localparam int FLAG_DAT   = 2;

    localparam logic [2:0] FLAGS_NONE  = 3'b000;
    localparam logic [2:0] FLAGS_READ  = 3'b101;
    localparam logic [2:0] FLAGS_WRITE = 3'b110;

endpackage

// File: rtl/sd_dat_xfer_ctrl_if.sv
// Interface bundling the CMD-side, buffer and bit-engine signals of the DAT transfer sequencer.
// The master side is whoever drives the inputs; the sequencer sits on the slave modport.
interface sd_dat_xfer_ctrl_if #(parameter int BLK_CNT_W = 16);

    logic                 command_end_i;
    logic                 command_complete_i;
    logic                 cmd_abort_i;
    logic                 resp_busy_i;
    logic                 data_present_i;
    logic                 dir_read_i;
    logic                 multi_block_i;
    logic                 blk_cnt_en_i;
    logic [BLK_CNT_W-1:0] blk_cnt_i;
    logic                 auto_cmd12_en_i;
    logic                 auto_cmd_done_i;
    logic                 gap_stop_i;
    logic                 gap_continue_i;
    logic                 read_wait_en_i;
    logic                 r_buf_full_i;
    logic                 w_buf_empty_i;
    logic                 blk_done_i;
    logic [2:0]           blk_err_i;
    logic                 sd_resumed_i;

    logic [1:0]           issue_o;
    logic                 pause_req_o;
    logic                 read_wait_o;
    logic                 auto_cmd12_issue_o;
    logic [BLK_CNT_W-1:0] block_count_o;
    logic [2:0]           xfer_active_o;
    logic                 transfer_complete_o;
    logic                 block_gap_o;
    logic [2:0]           data_err_o;

    modport master (
        output command_end_i, command_complete_i, cmd_abort_i, resp_busy_i,
               data_present_i, dir_read_i, multi_block_i, blk_cnt_en_i, blk_cnt_i,
               auto_cmd12_en_i, auto_cmd_done_i, gap_stop_i, gap_continue_i,
               read_wait_en_i, r_buf_full_i, w_buf_empty_i, blk_done_i, blk_err_i,
               sd_resumed_i,
        input  issue_o, pause_req_o, read_wait_o, auto_cmd12_issue_o, block_count_o,
               xfer_active_o, transfer_complete_o, block_gap_o, data_err_o
    );

    modport slave (
        input  command_end_i, command_complete_i, cmd_abort_i, resp_busy_i,
               data_present_i, dir_read_i, multi_block_i, blk_cnt_en_i, blk_cnt_i,
               auto_cmd12_en_i, auto_cmd_done_i, gap_stop_i, gap_continue_i,
               read_wait_en_i, r_buf_full_i, w_buf_empty_i, blk_done_i, blk_err_i,
               sd_resumed_i,
        output issue_o, pause_req_o, read_wait_o, auto_cmd12_issue_o, block_count_o,
               xfer_active_o, transfer_complete_o, block_gap_o, data_err_o
    );

endinterface

// File: rtl/sd_dat_xfer_ctrl.sv
// DAT-line transfer sequencer: orders block reads/writes, busy waits, block-gap handling
// and Auto CMD12 between the CMD logic and the external DAT bit engine.
module sd_dat_xfer_ctrl
    import sd_dat_xfer_ctrl_pkg::*;
#(
    parameter int BLK_CNT_W = 16,
    parameter bit READ_WAIT = 1'b1
) (
    input  logic                 sdclk_i,
    input  logic                 rst_dat_ni,
    sd_dat_xfer_ctrl_if.slave    bus
);

    xfer_state_e          state_q, state_d;
    logic [BLK_CNT_W-1:0] count_q, count_d;
    logic [2:0]           flags_q, flags_d;
    issue_e               issue;
    logic                 pause_req;
    logic                 read_wait;
    logic                 acmd12_issue;
    logic                 block_gap;
    logic [2:0]           data_err;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        flags_d      = flags_q;
        issue        = ISSUE_NONE;
        pause_req    = 1'b0;
        read_wait    = 1'b0;
        acmd12_issue = 1'b0;
        block_gap    = 1'b0;
        data_err     = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (bus.command_end_i && bus.data_present_i) begin
                    count_d = bus.multi_block_i ? (bus.blk_cnt_en_i ? bus.blk_cnt_i : '0)
                                                : BLK_CNT_W'(1);
                    if (bus.dir_read_i) begin
                        flags_d = FLAGS_READ;
                        issue   = ISSUE_READ;
                        state_d = ST_OP;
                    end else begin
                        flags_d = FLAGS_WRITE;
                    end
                end
                // Response handling is evaluated last so its transition wins a same-cycle command end.
                if (bus.command_complete_i) begin
                    if (bus.resp_busy_i) begin
                        issue             = ISSUE_BUSY;
                        flags_d[FLAG_DAT] = 1'b1;
                        state_d           = ST_BUSY;
                    end else if (flags_q[FLAG_WRITE] ||
                                 (bus.command_end_i && bus.data_present_i && !bus.dir_read_i)) begin
                        state_d = ST_WBUF;
                    end
                end
            end
            ST_WBUF: begin
                if (!bus.w_buf_empty_i) begin
                    issue   = ISSUE_WRITE;
                    state_d = ST_OP;
                end
            end
            ST_OP: begin
                if (bus.blk_done_i) begin
                    if (bus.blk_err_i != 3'b000) begin
                        data_err = {bus.blk_err_i[ERR_TIMEOUT], bus.blk_err_i[ERR_END_BIT],
                                    bus.blk_err_i[ERR_CRC]};
                        state_d  = ST_ERROR;
                    end else begin
                        count_d = (count_q == '0) ? '0 : count_q - BLK_CNT_W'(1);
                        if (count_q == BLK_CNT_W'(1)) begin
                            if (bus.auto_cmd12_en_i) begin
                                acmd12_issue = 1'b1;
                                state_d      = ST_ACMD12;
                            end else begin
                                flags_d = FLAGS_NONE;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            state_d = ST_COMP;
                        end
                    end
                end
            end
            ST_COMP: begin
                if (bus.gap_stop_i) begin
                    flags_d   = FLAGS_NONE;
                    block_gap = 1'b1;
                end
                if (flags_q[FLAG_READ]) begin
                    if (bus.gap_stop_i && bus.read_wait_en_i && READ_WAIT) begin
                        state_d = ST_RWAIT;
                    end else if (bus.r_buf_full_i || bus.gap_stop_i) begin
                        pause_req = 1'b1;
                        state_d   = ST_PAUSED;
                    end else begin
                        issue   = ISSUE_READ;
                        state_d = ST_OP;
                    end
                end else begin
                    state_d = bus.gap_stop_i ? ST_WGAP : ST_WBUF;
                end
            end
            ST_PAUSED: begin
                pause_req = 1'b1;
                if (bus.sd_resumed_i) begin
                    pause_req = 1'b0;
                    flags_d   = FLAGS_READ;
                    issue     = ISSUE_READ;
                    state_d   = ST_OP;
                end
            end
            ST_RWAIT: begin
                read_wait = !bus.gap_continue_i;
                if (bus.gap_continue_i) begin
                    flags_d = FLAGS_READ;
                    issue   = ISSUE_READ;
                    state_d = ST_OP;
                end
            end
            ST_WGAP: begin
                if (bus.gap_continue_i) begin
                    flags_d = FLAGS_WRITE;
                    state_d = ST_WBUF;
                end
            end
            ST_ACMD12: begin
                if (bus.auto_cmd_done_i) begin
                    issue   = ISSUE_BUSY;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.blk_done_i) begin
                    flags_d = FLAGS_NONE;
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An abort cancels whatever else this cycle would have done.
        if (bus.cmd_abort_i && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            flags_d      = FLAGS_NONE;
            count_d      = '0;
            issue        = ISSUE_NONE;
            pause_req    = 1'b0;
            read_wait    = 1'b0;
            acmd12_issue = 1'b0;
            block_gap    = 1'b0;
            data_err     = 3'b000;
        end
    end

    always_ff @(posedge sdclk_i or negedge rst_dat_ni) begin
        if (!rst_dat_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            flags_q <= FLAGS_NONE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

    assign bus.issue_o             = issue;
    assign bus.pause_req_o         = pause_req;
    assign bus.read_wait_o         = read_wait;
    assign bus.auto_cmd12_issue_o  = acmd12_issue;
    assign bus.block_count_o       = count_q;
    assign bus.xfer_active_o       = flags_q;
    assign bus.transfer_complete_o = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign bus.block_gap_o         = block_gap;
    assign bus.data_err_o          = data_err;

endmodule

// File: tb/tb_sd_dat_xfer_ctrl.sv
// Scoreboard bench for sd_dat_xfer_ctrl: expected output pulses are queued as stimulus is driven
// and retired in order by a negedge monitor; level outputs are checked directly.
module tb_sd_dat_xfer_ctrl;

    localparam int W = 16;

    localparam logic [6:0] P_CMD_END  = 7'b0000001;
    localparam logic [6:0] P_CMD_CPL  = 7'b0000010;
    localparam logic [6:0] P_ABORT    = 7'b0000100;
    localparam logic [6:0] P_BLK_DONE = 7'b0001000;
    localparam logic [6:0] P_GAP_CONT = 7'b0010000;
    localparam logic [6:0] P_ACMD_DN  = 7'b0100000;
    localparam logic [6:0] P_RESUMED  = 7'b1000000;

    localparam int EV_ISSUE_R = 32'h101;
    localparam int EV_ISSUE_W = 32'h102;
    localparam int EV_ISSUE_B = 32'h103;
    localparam int EV_ACMD12  = 32'h200;
    localparam int EV_GAP     = 32'h300;
    localparam int EV_ERR     = 32'h400;
    localparam int EV_TC      = 32'h500;

    logic sdclk;
    logic rst_dat_n;
    int   tests_run;
    int   tests_failed;
    int   expected_q[$];

    sd_dat_xfer_ctrl_if #(.BLK_CNT_W(W)) bus ();

    sd_dat_xfer_ctrl #(.BLK_CNT_W(W), .READ_WAIT(1'b1)) dut (
        .sdclk_i    (sdclk),
        .rst_dat_ni (rst_dat_n),
        .bus        (bus)
    );

    initial sdclk = 1'b0;
    always #5 sdclk = ~sdclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushExpected(input int code);
        expected_q.push_back(code);
    endtask

    task automatic scoreEvent(input int observed);
        int want;
        want = 0;
        if (expected_q.size() != 0) want = expected_q.pop_front();
        checkOutput("sb_event", observed, want);
    endtask

    // Pulse outputs are retired in a fixed per-cycle order that the pushes follow.
    always @(negedge sdclk) begin
        if (bus.issue_o != 2'b00)        scoreEvent(32'h100 | int'(bus.issue_o));
        if (bus.auto_cmd12_issue_o)      scoreEvent(EV_ACMD12);
        if (bus.block_gap_o)             scoreEvent(EV_GAP);
        if (bus.data_err_o != 3'b000)    scoreEvent(EV_ERR | int'(bus.data_err_o));
        if (bus.transfer_complete_o)     scoreEvent(EV_TC);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sdclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [6:0] pulses, input logic [2:0] err);
        bus.command_end_i      = pulses[0];
        bus.command_complete_i = pulses[1];
        bus.cmd_abort_i        = pulses[2];
        bus.blk_done_i         = pulses[3];
        bus.gap_continue_i     = pulses[4];
        bus.auto_cmd_done_i    = pulses[5];
        bus.sd_resumed_i       = pulses[6];
        bus.blk_err_i          = err;
        tick(1);
        bus.command_end_i      = 1'b0;
        bus.command_complete_i = 1'b0;
        bus.cmd_abort_i        = 1'b0;
        bus.blk_done_i         = 1'b0;
        bus.gap_continue_i     = 1'b0;
        bus.auto_cmd_done_i    = 1'b0;
        bus.sd_resumed_i       = 1'b0;
        bus.blk_err_i          = 3'b000;
    endtask

    task automatic setupCommand(input logic rd, input logic multi, input logic [W-1:0] cnt);
        bus.data_present_i = 1'b1;
        bus.dir_read_i     = rd;
        bus.multi_block_i  = multi;
        bus.blk_cnt_en_i   = 1'b1;
        bus.blk_cnt_i      = cnt;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_dat_n    = 1'b0;
        bus.command_end_i = 0; bus.command_complete_i = 0; bus.cmd_abort_i = 0;
        bus.resp_busy_i = 0; bus.data_present_i = 0; bus.dir_read_i = 0;
        bus.multi_block_i = 0; bus.blk_cnt_en_i = 0; bus.blk_cnt_i = '0;
        bus.auto_cmd12_en_i = 0; bus.auto_cmd_done_i = 0; bus.gap_stop_i = 0;
        bus.gap_continue_i = 0; bus.read_wait_en_i = 0; bus.r_buf_full_i = 0;
        bus.w_buf_empty_i = 0; bus.blk_done_i = 0; bus.blk_err_i = 3'b000;
        bus.sd_resumed_i = 0;
        tick(2);
        rst_dat_n = 1'b1;
        tick(1);

        checkOutput("rst_flags", bus.xfer_active_o, 3'b000);
        checkOutput("rst_count", bus.block_count_o, 0);
        checkOutput("rst_pause", bus.pause_req_o, 0);
        checkOutput("rst_rwait", bus.read_wait_o, 0);

        // Single read, one block.
        setupCommand(1'b1, 1'b0, 16'd9);
        pushExpected(EV_ISSUE_R);
        applyStimulus(P_CMD_END, 3'b000);
        checkOutput("rd1_flags", bus.xfer_active_o, 3'b101);
        checkOutput("rd1_count", bus.block_count_o, 1);
        pushExpected(EV_TC);
        applyStimulus(P_BLK_DONE, 3'b000);
        checkOutput("rd1_done_flags", bus.xfer_active_o, 3'b000);

        // Three-block write held off by an empty buffer.
        setupCommand(1'b0, 1'b1, 16'd3);
        bus.w_buf_empty_i = 1'b1;
        applyStimulus(P_CMD_END, 3'b000);
        checkOutput("wr_flags", bus.xfer_active_o, 3'b110);
        checkOutput("wr_count", bus.block_count_o, 3);
        applyStimulus(P_CMD_CPL, 3'b000);
        tick(5);
        pushExpected(EV_ISSUE_W);
        bus.w_buf_empty_i = 1'b0;
        tick(1);
        for (int b = 0; b < 3; b++) begin
            if (b == 2) pushExpected(EV_TC);
            applyStimulus(P_BLK_DONE, 3'b000);
            checkOutput("wr_count_dec", bus.block_count_o, 2 - b);
            if (b < 2) begin
                pushExpected(EV_ISSUE_W);
                tick(2);
            end
        end
        checkOutput("wr_done_flags", bus.xfer_active_o, 3'b000);

        // Four-block read stopped at the gap after block 2 using read-wait.
        setupCommand(1'b1, 1'b1, 16'd4);
        bus.read_wait_en_i = 1'b1;
        pushExpected(EV_ISSUE_R);
        applyStimulus(P_CMD_END, 3'b000);
        applyStimulus(P_BLK_DONE, 3'b000);
        pushExpected(EV_ISSUE_R);
        tick(1);
        bus.gap_stop_i = 1'b1;
        applyStimulus(P_BLK_DONE, 3'b000);
        pushExpected(EV_GAP);
        tick(1);
        checkOutput("rw_read_wait", bus.read_wait_o, 1);
        checkOutput("rw_flags", bus.xfer_active_o, 3'b000);
        checkOutput("rw_count", bus.block_count_o, 2);
        tick(3);
        checkOutput("rw_read_wait_hold", bus.read_wait_o, 1);
        bus.gap_stop_i = 1'b0;
        pushExpected(EV_ISSUE_R);
        bus.gap_continue_i = 1'b1;
        #2;
        checkOutput("rw_release", bus.read_wait_o, 0);
        tick(1);
        bus.gap_continue_i = 1'b0;
        checkOutput("rw_resume_flags", bus.xfer_active_o, 3'b101);
        applyStimulus(P_BLK_DONE, 3'b000);
        pushExpected(EV_ISSUE_R);
        tick(1);
        pushExpected(EV_TC);
        applyStimulus(P_BLK_DONE, 3'b000);
        checkOutput("rw_done_count", bus.block_count_o, 0);
        bus.read_wait_en_i = 1'b0;

        // Infinite read with a full buffer forcing an SDCLK pause, ended by abort.
        setupCommand(1'b1, 1'b1, 16'd0);
        pushExpected(EV_ISSUE_R);
        applyStimulus(P_CMD_END, 3'b000);
        bus.r_buf_full_i = 1'b1;
        applyStimulus(P_BLK_DONE, 3'b000);
        tick(1);
        checkOutput("ps_pause", bus.pause_req_o, 1);
        checkOutput("ps_flags", bus.xfer_active_o, 3'b101);
        tick(2);
        checkOutput("ps_pause_hold", bus.pause_req_o, 1);
        bus.r_buf_full_i = 1'b0;
        pushExpected(EV_ISSUE_R);
        applyStimulus(P_RESUMED, 3'b000);
        checkOutput("ps_released", bus.pause_req_o, 0);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(P_BLK_DONE, 3'b000);
            pushExpected(EV_ISSUE_R);
            tick(1);
        end
        checkOutput("inf_count", bus.block_count_o, 0);
        checkOutput("inf_active", bus.xfer_active_o, 3'b101);
        pushExpected(EV_TC);
        applyStimulus(P_ABORT, 3'b000);
        checkOutput("inf_abort_flags", bus.xfer_active_o, 3'b000);

        // Two-block read finished by Auto CMD12 and its busy phase.
        setupCommand(1'b1, 1'b1, 16'd2);
        bus.auto_cmd12_en_i = 1'b1;
        pushExpected(EV_ISSUE_R);
        applyStimulus(P_CMD_END, 3'b000);
        applyStimulus(P_BLK_DONE, 3'b000);
        pushExpected(EV_ISSUE_R);
        tick(1);
        pushExpected(EV_ACMD12);
        applyStimulus(P_BLK_DONE, 3'b000);
        checkOutput("ac_count", bus.block_count_o, 0);
        pushExpected(EV_ISSUE_B);
        applyStimulus(P_ACMD_DN, 3'b000);
        pushExpected(EV_TC);
        applyStimulus(P_BLK_DONE, 3'b000);
        checkOutput("ac_flags", bus.xfer_active_o, 3'b000);
        bus.auto_cmd12_en_i = 1'b0;

        // CRC error parks in ERROR until abort.
        setupCommand(1'b1, 1'b0, 16'd0);
        pushExpected(EV_ISSUE_R);
        applyStimulus(P_CMD_END, 3'b000);
        pushExpected(EV_ERR | 1);
        applyStimulus(P_BLK_DONE, 3'b001);
        tick(3);
        checkOutput("err_count_held", bus.block_count_o, 1);
        checkOutput("err_flags_held", bus.xfer_active_o, 3'b101);
        pushExpected(EV_TC);
        applyStimulus(P_ABORT, 3'b000);
        checkOutput("err_abort_count", bus.block_count_o, 0);
        checkOutput("err_abort_flags", bus.xfer_active_o, 3'b000);

        // Abort in the same cycle as an erroring block done: only the completion shows.
        pushExpected(EV_ISSUE_R);
        applyStimulus(P_CMD_END, 3'b000);
        pushExpected(EV_TC);
        applyStimulus(P_ABORT | P_BLK_DONE, 3'b100);
        checkOutput("abort_wins_flags", bus.xfer_active_o, 3'b000);

        // R1b response with no data goes straight to a busy wait.
        bus.data_present_i = 1'b0;
        bus.resp_busy_i    = 1'b1;
        pushExpected(EV_ISSUE_B);
        applyStimulus(P_CMD_CPL, 3'b000);
        bus.resp_busy_i = 1'b0;
        checkOutput("busy_flags", bus.xfer_active_o, 3'b100);
        pushExpected(EV_TC);
        applyStimulus(P_BLK_DONE, 3'b000);
        checkOutput("busy_done_flags", bus.xfer_active_o, 3'b000);

        // Command end and response in the same cycle for a single write.
        setupCommand(1'b0, 1'b0, 16'd7);
        bus.w_buf_empty_i = 1'b0;
        applyStimulus(P_CMD_END | P_CMD_CPL, 3'b000);
        checkOutput("same_cyc_flags", bus.xfer_active_o, 3'b110);
        pushExpected(EV_ISSUE_W);
        tick(1);
        pushExpected(EV_TC);
        applyStimulus(P_BLK_DONE, 3'b000);
        checkOutput("same_cyc_done", bus.xfer_active_o, 3'b000);

        // Asynchronous reset in the middle of a read.
        setupCommand(1'b1, 1'b1, 16'd5);
        pushExpected(EV_ISSUE_R);
        applyStimulus(P_CMD_END, 3'b000);
        tick(2);
        rst_dat_n = 1'b0;
        #1;
        checkOutput("arst_flags", bus.xfer_active_o, 3'b000);
        checkOutput("arst_count", bus.block_count_o, 0);
        checkOutput("arst_issue", bus.issue_o, 2'b00);
        tick(1);
        rst_dat_n = 1'b1;
        tick(2);
        checkOutput("arst_after_flags", bus.xfer_active_o, 3'b000);

        checkOutput("sb_leftover", expected_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
